// File: rtl/global_buffer_param.sv
// Shared global-buffer constants and types used by the configuration start pipeline.
package global_buffer_param;

    localparam int CFG_START_PIPE_DEPTH = 1;
    localparam int CFG_START_RD_TIMEOUT = 64;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } cfg_rd_state_e;

endpackage

// File: rtl/glb_pipe_stage.sv
// WIDTH-bit shift register of DEPTH stages with async active-low clear.
module glb_pipe_stage #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/glb_cfg_start_pipe.sv
// Pipelined config start block with per-channel read tracking.
// Read timeout is built only when GLB_CFG_START_PIPE_TIMEOUT_EN is defined.
//   state   | meaning
//   RD_IDLE | no read outstanding; a new rd_en is accepted
//   RD_WAIT | one read outstanding; further rd_en dropped and flagged
module glb_cfg_start_pipe
    import global_buffer_param::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          PIPE_DEPTH   = CFG_START_PIPE_DEPTH,
    parameter int          RD_TIMEOUT   = CFG_START_RD_TIMEOUT,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        cfg_wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] cfg_wr_data,
    input  logic [NUM_CH-1:0]        cfg_rd_en,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_rd_addr,
    output logic [NUM_CH*DATA_W-1:0] cfg_rd_data,
    output logic [NUM_CH-1:0]        cfg_rd_data_valid,
    output logic [NUM_CH-1:0]        cfg_rd_busy,
    output logic [NUM_CH-1:0]        est_wr_en,
    output logic [NUM_CH-1:0]        est_rd_en,
    output logic [NUM_CH*ADDR_W-1:0] est_wr_addr,
    output logic [NUM_CH*ADDR_W-1:0] est_rd_addr,
    output logic [NUM_CH*DATA_W-1:0] est_wr_data,
    output logic [NUM_CH-1:0]        est_wr_clk_en,
    output logic [NUM_CH-1:0]        est_rd_clk_en,
    input  logic [NUM_CH*DATA_W-1:0] est_rd_data,
    input  logic [NUM_CH-1:0]        est_rd_data_valid,
    input  logic                     err_clr,
    output logic [NUM_CH*2-1:0]      err_flags
);

    localparam int REQ_W = 2 + 2*ADDR_W + DATA_W;
    localparam int RSP_W = 1 + DATA_W;
    localparam logic [DATA_W-1:0] TIMEOUT_WORD = DATA_W'(TIMEOUT_DATA);
`ifdef GLB_CFG_START_PIPE_TIMEOUT_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
`endif

    assign est_wr_clk_en = {NUM_CH{1'b1}};
    assign est_rd_clk_en = {NUM_CH{1'b1}};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        cfg_rd_state_e     state_q, state_d;
        logic              rd_accept, emit, timeout_hit;
        logic              rsp_valid;
        logic [DATA_W-1:0] rsp_data, emit_data, last_q;
        logic [1:0]        err_q, err_set;
        logic [REQ_W-1:0]  req_d, req_q;
        logic [RSP_W-1:0]  rsp_d, rsp_q;

        // Only accepted reads travel east; dropped ones leave a zero bubble.
        assign req_d = {cfg_wr_en[ch], cfg_wr_addr[ch*ADDR_W +: ADDR_W],
                        cfg_wr_data[ch*DATA_W +: DATA_W], rd_accept,
                        {ADDR_W{rd_accept}} & cfg_rd_addr[ch*ADDR_W +: ADDR_W]};

        glb_pipe_stage #(.WIDTH(REQ_W), .DEPTH(PIPE_DEPTH)) u_req_pipe (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (req_d),
            .q       (req_q)
        );

        assign {est_wr_en[ch], est_wr_addr[ch*ADDR_W +: ADDR_W], est_wr_data[ch*DATA_W +: DATA_W],
                est_rd_en[ch], est_rd_addr[ch*ADDR_W +: ADDR_W]} = req_q;

        assign rsp_d = {est_rd_data_valid[ch], est_rd_data[ch*DATA_W +: DATA_W]};

        glb_pipe_stage #(.WIDTH(RSP_W), .DEPTH(PIPE_DEPTH)) u_rsp_pipe (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (rsp_d),
            .q       (rsp_q)
        );

        assign {rsp_valid, rsp_data} = rsp_q;

`ifdef GLB_CFG_START_PIPE_TIMEOUT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (state_q == RD_IDLE) cnt_d = '0;
            else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end

        assign timeout_hit = (state_q == RD_WAIT) && (cnt_q == CNT_LAST);
`else
        assign timeout_hit = 1'b0;
`endif

        always_comb begin
            state_d   = state_q;
            rd_accept = 1'b0;
            emit      = 1'b0;
            emit_data = rsp_data;
            err_set   = 2'b00;
            case (state_q)
                RD_IDLE: begin
                    err_set[0] = rsp_valid;
                    if (cfg_rd_en[ch]) begin
                        rd_accept = 1'b1;
                        state_d   = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    err_set[1] = cfg_rd_en[ch];
                    // A real response beats a coincident timeout.
                    if (rsp_valid) begin
                        emit    = 1'b1;
                        state_d = RD_IDLE;
                    end else if (timeout_hit) begin
                        emit       = 1'b1;
                        emit_data  = TIMEOUT_WORD;
                        err_set[0] = 1'b1;
                        state_d    = RD_IDLE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= RD_IDLE;
                last_q  <= '0;
                err_q   <= 2'b00;
            end else begin
                state_q <= state_d;
                if (emit) last_q <= emit_data;
                err_q <= (err_clr ? 2'b00 : err_q) | err_set;
            end
        end

        assign cfg_rd_data_valid[ch]            = emit;
        assign cfg_rd_data[ch*DATA_W +: DATA_W] = emit ? emit_data : last_q;
        assign cfg_rd_busy[ch]                  = (state_q == RD_WAIT);
        assign err_flags[ch*2 +: 2]             = err_q;
    end

endmodule

// File: tb/tb_glb_cfg_start_pipe.sv
// Scoreboard bench for glb_cfg_start_pipe; expectations adapt to GLB_CFG_START_PIPE_TIMEOUT_EN.
module tb_glb_cfg_start_pipe;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int D   = 2;
    localparam int T   = 16;
    localparam logic [31:0] TO_WORD = 32'hDEAD_BEEF;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    cfg_wr_en = '0;
    logic [NCH*AW-1:0] cfg_wr_addr = '0;
    logic [NCH*DW-1:0] cfg_wr_data = '0;
    logic [NCH-1:0]    cfg_rd_en = '0;
    logic [NCH*AW-1:0] cfg_rd_addr = '0;
    logic [NCH*DW-1:0] cfg_rd_data;
    logic [NCH-1:0]    cfg_rd_data_valid, cfg_rd_busy;
    logic [NCH-1:0]    est_wr_en, est_rd_en, est_wr_clk_en, est_rd_clk_en;
    logic [NCH*AW-1:0] est_wr_addr, est_rd_addr;
    logic [NCH*DW-1:0] est_wr_data;
    logic [NCH*DW-1:0] est_rd_data = '0;
    logic [NCH-1:0]    est_rd_data_valid = '0;
    logic              err_clr = 1'b0;
    logic [NCH*2-1:0]  err_flags;

    always #5 clk = ~clk;

    glb_cfg_start_pipe #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .PIPE_DEPTH(D),
        .RD_TIMEOUT(T), .TIMEOUT_DATA(TO_WORD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr),
        .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid), .cfg_rd_busy(cfg_rd_busy),
        .est_wr_en(est_wr_en), .est_rd_en(est_rd_en),
        .est_wr_addr(est_wr_addr), .est_rd_addr(est_rd_addr), .est_wr_data(est_wr_data),
        .est_wr_clk_en(est_wr_clk_en), .est_rd_clk_en(est_rd_clk_en),
        .est_rd_data(est_rd_data), .est_rd_data_valid(est_rd_data_valid),
        .err_clr(err_clr), .err_flags(err_flags)
    );

    exp_t            wr_q [NCH][$];
    exp_t            rd_q [NCH][$];
    exp_t            em_q [NCH][$];
    bit              err0_ev [int];
    bit              drop_ev [int];
    bit              clr_ev [int];
    logic [31:0]     resp_at [int];
    int              busy_lo [NCH];
    int              busy_hi [NCH];
    int              block_until [NCH];
    logic [31:0]     last_data [NCH];
    logic [2*NCH-1:0] mflags = '0;
    int              n_tests = 0;
    int              n_fail = 0;
    bit              mon_en = 1'b0;
    int              cyc = 0;
    logic [31:0]     d_addr = '0, d_data = '0, d_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int key(input int c, input int ch);
        return c * NCH + ch;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: applies recorded events of the previous cycle, then compares.
    task automatic monitor_cycle();
        int c;
        bit exp_v;
        logic [2*NCH-1:0] nf;
        c  = cyc;
        nf = clr_ev.exists(c - 1) ? '0 : mflags;
        for (int ch = 0; ch < NCH; ch++) begin
            if (err0_ev.exists(key(c - 1, ch))) nf[2*ch]   = 1'b1;
            if (drop_ev.exists(key(c - 1, ch))) nf[2*ch+1] = 1'b1;
        end
        mflags = nf;
        chk("err_flags", err_flags, mflags);
        chk("clk_en", {est_wr_clk_en, est_rd_clk_en}, {2*NCH{1'b1}});
        for (int ch = 0; ch < NCH; ch++) begin
            exp_v = (wr_q[ch].size() > 0) && (wr_q[ch][0].due == c);
            chk("est_wr_en", est_wr_en[ch], exp_v);
            if (exp_v) begin
                chk("est_wr_addr", est_wr_addr[ch*AW +: AW], wr_q[ch][0].addr);
                chk("est_wr_data", est_wr_data[ch*DW +: DW], wr_q[ch][0].data);
                void'(wr_q[ch].pop_front());
            end
            exp_v = (rd_q[ch].size() > 0) && (rd_q[ch][0].due == c);
            chk("est_rd_en", est_rd_en[ch], exp_v);
            if (exp_v) begin
                chk("est_rd_addr", est_rd_addr[ch*AW +: AW], rd_q[ch][0].addr);
                void'(rd_q[ch].pop_front());
            end
            exp_v = (em_q[ch].size() > 0) && (em_q[ch][0].due == c);
            chk("rd_valid", cfg_rd_data_valid[ch], exp_v);
            if (exp_v) begin
                last_data[ch] = em_q[ch][0].data;
                void'(em_q[ch].pop_front());
            end
            chk("rd_data", cfg_rd_data[ch*DW +: DW], last_data[ch]);
            chk("rd_busy", cfg_rd_busy[ch], (c >= busy_lo[ch]) && (c <= busy_hi[ch]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) monitor_cycle();
        end
    end

    // One stimulus cycle; the tile-chain responder is part of the bench.
    task automatic step(input bit rnd, input logic [NCH-1:0] f_wr, input logic [NCH-1:0] f_rd,
                        input int f_dly, input bit f_clr);
        int c, dly, r, arr;
        bit busy_now, do_wr, do_rd, to;
        logic [31:0] wa, wd, ra, rdat;
        @(negedge clk);
        c = cyc;
        cfg_wr_en = '0;
        cfg_rd_en = '0;
        est_rd_data_valid = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            busy_now = (c >= busy_lo[ch]) && (c <= busy_hi[ch]);
            do_wr = rnd ? ($urandom_range(2) == 0) : f_wr[ch];
            do_rd = rnd ? ($urandom_range(3) == 0) : f_rd[ch];
            wa    = rnd ? $urandom : d_addr;
            wd    = rnd ? $urandom : d_data;
            ra    = rnd ? $urandom : d_addr;
            rdat  = rnd ? $urandom : d_rdata;
            cfg_wr_addr[ch*AW +: AW] = wa;
            cfg_wr_data[ch*DW +: DW] = wd;
            cfg_rd_addr[ch*AW +: AW] = ra;
            if (do_wr) begin
                cfg_wr_en[ch] = 1'b1;
                wr_q[ch].push_back('{c + D, wa, wd});
            end
            if (do_rd && busy_now) begin
                cfg_rd_en[ch] = 1'b1;
                drop_ev[key(c, ch)] = 1'b1;
            end else if (do_rd && c > block_until[ch]) begin
                dly = rnd ? int'($urandom_range(20)) : f_dly;
                cfg_rd_en[ch] = 1'b1;
                rd_q[ch].push_back('{c + D, ra, 32'h0});
                r   = c + D + dly;
                arr = r + D;
                resp_at[key(r, ch)] = rdat;
                to = 1'b0;
`ifdef GLB_CFG_START_PIPE_TIMEOUT_EN
                to = (arr > c + T);
`endif
                busy_lo[ch] = c + 1;
                if (to) begin
                    em_q[ch].push_back('{c + T, ra, TO_WORD});
                    err0_ev[key(c + T, ch)] = 1'b1;
                    err0_ev[key(arr, ch)]   = 1'b1;
                    busy_hi[ch] = c + T;
                end else begin
                    em_q[ch].push_back('{arr, ra, rdat});
                    busy_hi[ch] = arr;
                end
                block_until[ch] = arr;
            end else if (rnd && !busy_now && c > block_until[ch] && $urandom_range(15) == 0) begin
                resp_at[key(c, ch)] = $urandom;
                err0_ev[key(c + D, ch)] = 1'b1;
                block_until[ch] = c + D;
            end
            if (resp_at.exists(key(c, ch))) begin
                est_rd_data_valid[ch]    = 1'b1;
                est_rd_data[ch*DW +: DW] = resp_at[key(c, ch)];
            end else begin
                est_rd_data[ch*DW +: DW] = $urandom;
            end
        end
        err_clr = rnd ? ($urandom_range(19) == 0) : f_clr;
        if (err_clr) clr_ev[c] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset_n = 1'b0;
        cfg_wr_en = '0;
        cfg_rd_en = '0;
        est_rd_data_valid = '0;
        err_clr = 1'b0;
        #1;
        chk("rst_est_wr_en", est_wr_en, '0);
        chk("rst_est_rd_en", est_rd_en, '0);
        chk("rst_est_wr_addr", est_wr_addr, '0);
        chk("rst_est_wr_data", est_wr_data, '0);
        chk("rst_est_rd_addr", est_rd_addr, '0);
        chk("rst_rd_valid", cfg_rd_data_valid, '0);
        chk("rst_rd_data", cfg_rd_data, '0);
        chk("rst_rd_busy", cfg_rd_busy, '0);
        chk("rst_err_flags", err_flags, '0);
        chk("rst_clk_en", {est_wr_clk_en, est_rd_clk_en}, {2*NCH{1'b1}});
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            wr_q[ch].delete();
            rd_q[ch].delete();
            em_q[ch].delete();
            busy_lo[ch] = 1;
            busy_hi[ch] = 0;
            block_until[ch] = cyc;
            last_data[ch] = '0;
        end
        err0_ev.delete();
        drop_ev.delete();
        clr_ev.delete();
        resp_at.delete();
        mflags = '0;
        reset_n = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();
        // Write on ch0 only.
        d_addr = 32'h10; d_data = 32'hA5;
        step(1'b0, 2'b01, 2'b00, 0, 1'b0);
        idle(6);
        // Read on ch1, response three cycles after est_rd_en.
        d_addr = 32'h20; d_rdata = 32'h1234;
        step(1'b0, 2'b00, 2'b10, 3, 1'b0);
        idle(10);
        // Response arrives five cycles past the timeout point.
        d_addr = 32'h30; d_rdata = 32'h5555_0001;
        step(1'b0, 2'b00, 2'b01, T + 5 - 2*D, 1'b0);
        idle(26);
        step(1'b0, 2'b00, 2'b00, 0, 1'b1);
        idle(3);
        // Second read while busy is dropped.
        d_addr = 32'h40; d_rdata = 32'h0000_0A0B;
        step(1'b0, 2'b00, 2'b01, 6, 1'b0);
        d_addr = 32'h44;
        step(1'b0, 2'b00, 2'b01, 0, 1'b0);
        idle(14);
        // Response lands exactly on the timeout cycle.
        d_addr = 32'h50; d_rdata = 32'hC0FF_EE00;
        step(1'b0, 2'b00, 2'b01, T - 2*D, 1'b0);
        idle(20);
        repeat (2500) step(1'b1, '0, '0, 0, 1'b0);
        do_reset();
        repeat (1500) step(1'b1, '0, '0, 0, 1'b0);
        idle(60);
        for (int ch = 0; ch < NCH; ch++) begin
            chk("wr_q_drained", wr_q[ch].size(), 0);
            chk("rd_q_drained", rd_q[ch].size(), 0);
            chk("em_q_drained", em_q[ch].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
